// File: rtl/bf16_mm_pkg.sv
// Shared types and constants for the
// bfloat16 matrix stream controller slice.
package bf16_mm_pkg;

  localparam int MM_N    = 16;
  localparam int MM_SIZE = 4;

  typedef logic [15:0] bf16_t;

  localparam bf16_t BF16_ONE   = 16'h3F80;
  localparam bf16_t BF16_TWO   = 16'h4000;
  localparam bf16_t BF16_THREE = 16'h4040;
  localparam bf16_t BF16_FOUR  = 16'h4080;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DRAIN
  } mm_state_e;

endpackage

// File: rtl/bfloat16_matrix_stream_controller_if.sv
// Element stream bundle: operand beats in,
// result beats out, both valid/ready.
interface bfloat16_matrix_stream_controller_if
  import bf16_mm_pkg::*;
#(
  parameter int N = MM_N
) ();

  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_data;
  logic         m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/bfloat16_matrix_serializer.sv
// Holds the captured C matrix and streams it
// out row-major under valid/ready.
module bfloat16_matrix_serializer
  import bf16_mm_pkg::*;
#(
  parameter int N    = MM_N,
  parameter int SIZE = MM_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cap,
  input  logic [SIZE-1:0][SIZE-1:0][N-1:0] c_in,
  input  logic                             m_ready,
  output logic                             m_valid,
  output logic [N-1:0]                     m_data,
  output logic                             m_last,
  output logic                             done
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [SIZE-1:0][SIZE-1:0][N-1:0] c_buf;
  logic [IW-1:0]                    row;
  logic [IW-1:0]                    col;
  logic                             at_end;

  assign at_end = (row == IW'(SIZE - 1))
               && (col == IW'(SIZE - 1));
  assign m_data = c_buf[row][col];
  assign m_last = m_valid && at_end;
  assign done   = m_valid && m_ready && at_end;

  // Capture C on the strobe, then walk it.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_buf   <= '0;
      row     <= '0;
      col     <= '0;
      m_valid <= 1'b0;
    end else if (cap) begin
      c_buf   <= c_in;
      row     <= '0;
      col     <= '0;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      if (at_end) begin
        m_valid <= 1'b0;
        row     <= '0;
        col     <= '0;
      end else if (col == IW'(SIZE - 1)) begin
        col <= '0;
        row <= row + IW'(1);
      end else begin
        col <= col + IW'(1);
      end
    end
  end

endmodule

// File: rtl/bfloat16_matrix_stream_controller.sv
// Stream initiator for one bf16 matrix multiplier.
// MM_TIMEOUT_EN enables the WAIT watchdog and err.
module bfloat16_matrix_stream_controller
  import bf16_mm_pkg::*;
#(
  parameter int N              = MM_N,
  parameter int SIZE           = MM_SIZE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  bfloat16_matrix_stream_controller_if.slave bus,
  output logic [SIZE-1:0][SIZE-1:0][N-1:0] mm_a,
  output logic [SIZE-1:0][SIZE-1:0][N-1:0] mm_b,
  output logic [SIZE*SIZE*SIZE-1:0]        mm_op_start,
  input  logic [SIZE*SIZE-1:0]             mm_op_finish,
  input  logic [SIZE-1:0][SIZE-1:0][N-1:0] mm_c,
  output logic                             busy,
  output logic                             err
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  mm_state_e            state;
  mm_state_e            state_nx;
  logic [IW-1:0]        row;
  logic [IW-1:0]        col;
  logic                 phase_b;
  logic                 s_fire;
  logic                 last_beat;
  logic [SIZE*SIZE-1:0] sticky;
  logic                 all_fin;
  logic                 cap;
  logic                 to_hit;
  logic                 drain_done;
  logic                 ser_valid;
  logic                 ser_last;
  logic [N-1:0]         ser_data;

  assign s_fire    = bus.s_valid && bus.s_ready;
  assign last_beat = phase_b
                  && (row == IW'(SIZE - 1))
                  && (col == IW'(SIZE - 1));
  assign all_fin   = &(sticky | mm_op_finish);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (s_fire) state_nx = LOAD;
      LOAD:    if (s_fire && last_beat) state_nx = START;
      START:   state_nx = WAIT;
      WAIT: begin
        if (all_fin)     state_nx = DRAIN;
        else if (to_hit) state_nx = IDLE;
      end
      DRAIN:   if (drain_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded control outputs.
  always_comb begin
    bus.s_ready = 1'b0;
    busy        = 1'b0;
    mm_op_start = '0;
    cap         = 1'b0;
    unique case (state)
      IDLE:  bus.s_ready = !rst;
      LOAD: begin
        bus.s_ready = !rst;
        busy        = 1'b1;
      end
      START: begin
        busy        = 1'b1;
        mm_op_start = '1;
      end
      WAIT: begin
        busy = 1'b1;
        cap  = all_fin;
      end
      DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  // Scatter A then B into transposed layout.
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_a    <= '0;
      mm_b    <= '0;
      row     <= '0;
      col     <= '0;
      phase_b <= 1'b0;
    end else if (s_fire) begin
      if (phase_b) mm_b[col][row] <= bus.s_data;
      else         mm_a[col][row] <= bus.s_data;
      if (col == IW'(SIZE - 1)) begin
        col <= '0;
        if (row == IW'(SIZE - 1)) begin
          row     <= '0;
          phase_b <= !phase_b;
        end else begin
          row <= row + IW'(1);
        end
      end else begin
        col <= col + IW'(1);
      end
    end
  end

  // Finish bits only count from WAIT onward.
  always_ff @(posedge clk) begin
    if (rst || state == START)
      sticky <= '0;
    else if (state == WAIT)
      sticky <= sticky | mm_op_finish;
  end

`ifdef MM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  assign to_hit = (state == WAIT) && !all_fin
               && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in WAIT.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) to_cnt <= '0;
    else                      to_cnt <= to_cnt + TW'(1);
  end

  // Sticky timeout flag, cleared by a new job.
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (to_hit)
      err <= 1'b1;
    else if (s_fire && state == IDLE)
      err <= 1'b0;
  end
`else
  logic unused_cfg;

  assign unused_cfg = |TIMEOUT_CYCLES;
  assign to_hit     = 1'b0;
  assign err        = 1'b0;
`endif

  bfloat16_matrix_serializer #(
    .N    (N),
    .SIZE (SIZE)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .cap     (cap),
    .c_in    (mm_c),
    .m_ready (bus.m_ready),
    .m_valid (ser_valid),
    .m_data  (ser_data),
    .m_last  (ser_last),
    .done    (drain_done)
  );

  assign bus.m_valid = ser_valid;
  assign bus.m_data  = ser_data;
  assign bus.m_last  = ser_last;

endmodule

// File: tb/tb_bfloat16_matrix_stream_controller.sv
// Directed bench for the bf16 matrix stream
// controller with a stub multiplier.
module tb_bfloat16_matrix_stream_controller;
  import bf16_mm_pkg::*;

  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int SS   = SIZE * SIZE;
  localparam int TO   = 1024;

  typedef logic [SIZE-1:0][SIZE-1:0][N-1:0] mat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bfloat16_matrix_stream_controller_if #(.N(N)) bus ();

  mat_t               mm_a;
  mat_t               mm_b;
  mat_t               mm_c;
  logic [SS*SIZE-1:0] mm_op_start;
  logic [SS-1:0]      mm_op_finish;
  logic               busy;
  logic               err;

  bfloat16_matrix_stream_controller #(
    .N              (N),
    .SIZE           (SIZE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .mm_a         (mm_a),
    .mm_b         (mm_b),
    .mm_op_start  (mm_op_start),
    .mm_op_finish (mm_op_finish),
    .mm_c         (mm_c),
    .busy         (busy),
    .err          (err)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  bf16_t pat  [SIZE];
  bf16_t ctab [SIZE];
  mat_t  exp_op;
  mat_t  bad_c;
  bit    saw_mv;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stub multiplier: real C only for the right layout.
  function automatic mat_t stub_c();
    mat_t c;
    bit   ok;
    ok = (mm_a === exp_op) && (mm_b === exp_op);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        c[i][j] = ok ? ctab[j] : 16'hBAD0;
    return c;
  endfunction

  task automatic send(input logic [15:0] d,
                      input int gap);
    bit acc;
    int guard;
    repeat (gap) tick();
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    guard = 0;
    do begin
      acc = bus.s_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    bus.s_valid = 1'b0;
    if (!acc) chk("s_accept", 0, 1);
  endtask

  task automatic load(input int nbeats,
                      input bit gaps,
                      input bit early,
                      input logic [15:0] fill);
    for (int k = 0; k < nbeats; k++) begin
      if (early && k == 10) mm_op_finish = '1;
      send((fill == 16'h0) ? pat[k % SIZE] : fill,
           gaps ? (k * 7) % 3 : 0);
      mm_op_finish = '0;
    end
  endtask

  task automatic drain(input bit stalls);
    int          guard;
    bit          bad;
    logic [15:0] hold;
    for (int idx = 0; idx < SS; idx++) begin
      guard = 0;
      while (!bus.m_valid && guard < 50) begin
        tick();
        guard++;
      end
      if (!bus.m_valid) begin
        chk("m_valid_wait", 0, 1);
        return;
      end
      chk($sformatf("c%0d", idx),
          bus.m_data, ctab[idx % SIZE]);
      chk($sformatf("last%0d", idx),
          bus.m_last, idx == SS - 1);
      if (stalls && (idx % 3) != 0) begin
        hold = bus.m_data;
        bad  = 1'b0;
        bus.m_ready = 1'b0;
        repeat (idx % 3 + 1) begin
          tick();
          if (!bus.m_valid || bus.m_data !== hold
              || bus.m_last !== (idx == SS - 1))
            bad = 1'b1;
        end
        chk($sformatf("stall%0d", idx), bad, 0);
        bus.m_ready = 1'b1;
      end
      tick();
    end
    chk("busy_end", busy, 0);
    chk("m_valid_end", bus.m_valid, 0);
  endtask

  task automatic run(input bit gaps,
                     input bit stalls,
                     input bit staggered,
                     input bit early);
    bit early_v;
    load(2 * SS, gaps, early, 16'h0);
    chk("start_hi", mm_op_start, {SS*SIZE{1'b1}});
    chk("mm_a", mm_a, exp_op);
    chk("mm_b", mm_b, exp_op);
    mm_c = bad_c;
    tick();
    chk("start_lo", mm_op_start, 0);
    if (!staggered) begin
      tick();
      mm_op_finish = '1;
    end else begin
      early_v = 1'b0;
      for (int i = 0; i < SS - 1; i++) begin
        mm_op_finish = SS'(1) << i;
        tick();
        early_v |= bus.m_valid;
      end
      mm_op_finish = SS'(1) << (SS - 1);
      chk("early_drain", early_v, 0);
    end
    mm_c = stub_c();
    chk("m_valid_pre", bus.m_valid, 0);
    tick();
    mm_op_finish = '0;
    mm_c = bad_c;
    chk("m_valid_lat", bus.m_valid, 1);
    drain(stalls);
    chk("mm_a_held", mm_a, exp_op);
  endtask

  initial begin
    pat[0]  = BF16_ONE;
    pat[1]  = BF16_TWO;
    pat[2]  = BF16_THREE;
    pat[3]  = BF16_FOUR;
    ctab[0] = 16'h4120;
    ctab[1] = 16'h41A0;
    ctab[2] = 16'h41F0;
    ctab[3] = 16'h4220;
    for (int c = 0; c < SIZE; c++)
      for (int r = 0; r < SIZE; r++) begin
        exp_op[c][r] = pat[c];
        bad_c[c][r]  = 16'hBAD0;
      end
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b1;
    mm_op_finish = '0;
    mm_c         = '0;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_start", mm_op_start, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    rst = 1'b0;
    tick();
    chk("idle_s_ready", bus.s_ready, 1);

    run(1'b0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0, 1'b0);

    load(20, 1'b0, 1'b0, 16'h1111);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mm_a", mm_a, 0);
    chk("mid_rst_mm_b", mm_b, 0);
    chk("mid_rst_s_ready", bus.s_ready, 0);
    rst = 1'b0;
    tick();
    run(1'b0, 1'b0, 1'b0, 1'b0);

    run(1'b0, 1'b0, 1'b1, 1'b1);

`ifdef MM_TIMEOUT_EN
    load(2 * SS, 1'b0, 1'b0, 16'h0);
    saw_mv = 1'b0;
    repeat (TO) begin
      tick();
      saw_mv |= bus.m_valid;
    end
    chk("to_err_pre", err, 0);
    chk("to_busy_pre", busy, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_no_mv", saw_mv | bus.m_valid, 0);
    send(pat[0], 0);
    chk("to_err_clr", err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

endmodule
